// File: rtl/spi_pkg.sv
// Shared SPI definitions: word widths, default timing and the initiator state encoding.
// The omega word width lives here so the host side and the receiver agree on frame length.
package spi_pkg;

    localparam int SPI_WORD_W      = 64;
    localparam int SPI_CLK_DIV_DEF = 4;
    localparam int SPI_CS_GAP_DEF  = 4;
    localparam int OMEGA_W         = SPI_WORD_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_sck_div.sv
// Half-period timer: one-cycle tick every CLK_DIV clocks; sync clear restarts the count at zero.
// The tick is high on the last cycle of each half-period, so the next sck edge lands exactly CLK_DIV clocks after a clear.
module spi_sck_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 initiator sending one WIDTH-bit word per frame, MSB first; all outputs registered.
// Accepts only in IDLE (tx_ready); words offered while busy are dropped, tx_valid held high gives back-to-back frames.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int WIDTH   = SPI_WORD_W,
    parameter int CLK_DIV = SPI_CLK_DIV_DEF,
    parameter int CS_GAP  = SPI_CS_GAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sck,
    output logic             mosi,
    output logic             ssel,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    // The IDLE cycle before the next accept also holds ssel high, so GAP itself is one cycle shorter.
    localparam int GAP_CYC = (CS_GAP > 1) ? CS_GAP - 1 : 1;
    localparam int GW = $clog2(GAP_CYC + 1);

    spi_state_e       state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [BW-1:0]    bit_cnt, bit_cnt_nx;
    logic [GW-1:0]    gap_cnt, gap_cnt_nx;
    logic             sck_nx, mosi_nx, ssel_nx, busy_nx, done_nx;
    logic             accept;
    logic             tick;

    assign tx_ready = (state == IDLE);
    assign accept   = tx_valid && tx_ready;

    spi_sck_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            ssel    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            bit_cnt <= bit_cnt_nx;
            gap_cnt <= gap_cnt_nx;
            sck     <= sck_nx;
            mosi    <= mosi_nx;
            ssel    <= ssel_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        gap_cnt_nx = gap_cnt;
        sck_nx     = sck;
        mosi_nx    = mosi;
        ssel_nx    = ssel;
        busy_nx    = busy;
        done_nx    = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx   = SETUP;
                    shreg_nx   = tx_data;
                    mosi_nx    = tx_data[WIDTH-1];
                    ssel_nx    = 1'b0;
                    busy_nx    = 1'b1;
                    bit_cnt_nx = '0;
                end
            end
            SETUP: begin
                if (tick) begin
                    sck_nx   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                // bit_cnt holds the index of the most recent rising edge
                if (tick) begin
                    if (sck) begin
                        sck_nx = 1'b0;
                        if (bit_cnt == BW'(WIDTH - 1)) begin
                            state_nx = HOLD;
                        end else begin
                            shreg_nx = shreg << 1;
                            mosi_nx  = shreg[WIDTH-2];
                        end
                    end else begin
                        sck_nx     = 1'b1;
                        bit_cnt_nx = bit_cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    ssel_nx    = 1'b1;
                    mosi_nx    = 1'b0;
                    done_nx    = 1'b1;
                    gap_cnt_nx = '0;
                    state_nx   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYC - 1)) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end else begin
                    gap_cnt_nx = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: a behavioural SPI receiver/protocol monitor plus directed and random frames.
`timescale 1ns/1ps
module tb_spi_master_tx;

    localparam int W       = 64;
    localparam int DIV     = 4;
    localparam int GAPC    = 4;
    localparam int T_FIRST = DIV;
    localparam int T_LAST  = (2 * (W - 1) + 1) * DIV;
    localparam int T_END   = (2 * W + 1) * DIV;
    localparam int T_NEXT  = T_END + GAPC;
    localparam int BOUND   = 3000;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready, sck, mosi, ssel, busy, done;

    spi_master_tx #(.WIDTH(W), .CLK_DIV(DIV), .CS_GAP(GAPC)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .sck      (sck),
        .mosi     (mosi),
        .ssel     (ssel),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: shifts mosi on each sck rise inside a frame, keeps only complete words.
    logic [W-1:0] shv = '0;
    logic [W-1:0] rx_q[$];
    logic prev_sck = 1'b0, prev_ssel = 1'b1, prev_mosi = 1'b0, prev_done = 1'b0;
    int rises = 0, first_rise = 0, last_rise = 0, ssel_rise = 0, last_gap = 0;
    int done_cnt = 0, done_cyc = 0, proto_err = 0, partial = 0, frames_started = 0;

    always @(negedge clk) begin
        if (!ssel && prev_ssel) begin
            frames_started++;
            last_gap = cyc - ssel_rise;
            rises = 0;
            shv = '0;
        end
        if ((sck !== prev_sck) && (ssel || prev_ssel)) proto_err++;
        if ((ssel !== prev_ssel) && (sck || prev_sck)) proto_err++;
        if (sck && prev_sck && (mosi !== prev_mosi)) proto_err++;
        if (ssel && mosi) proto_err++;
        if (done && (prev_done || !(ssel && !prev_ssel))) proto_err++;
        if (sck && !prev_sck) begin
            shv = {shv[W-2:0], mosi};
            if (rises == 0) first_rise = cyc;
            last_rise = cyc;
            rises++;
        end
        if (ssel && !prev_ssel) begin
            ssel_rise = cyc;
            if (rises == W) rx_q.push_back(shv);
            else partial++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_sck  = sck;
        prev_ssel = ssel;
        prev_mosi = mosi;
        prev_done = done;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int rc);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", tx_ready, 1);
        rc = cyc;
    endtask

    task automatic send(input logic [W-1:0] w, output int e0);
        int rc;
        wait_ready(rc);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        e0 = cyc;
        tx_valid = 1'b0;
    endtask

    task automatic check_rx(input string tag, input logic [W-1:0] exp);
        check({tag, "_rx_present"}, (rx_q.size() > 0), 1);
        if (rx_q.size() > 0) check({tag, "_rx_word"}, rx_q.pop_front(), exp);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w, w2, exp_q[$];
        int e0, e1, rc, dc, pb, fs, ds;

        rst = 1'b1;
        tx_valid = 1'b0;
        tx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ssel", ssel, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", tx_ready, 1);
        rst = 1'b0;

        // Single frame with exact edge timing
        w = 64'h0123_4567_89AB_CDEF;
        send(w, e0);
        check("t1_ssel_low", ssel, 0);
        check("t1_busy", busy, 1);
        check("t1_ready_low", tx_ready, 0);
        check("t1_mosi_msb", mosi, w[W-1]);
        check("t1_sck_low", sck, 0);
        wait_ready(rc);
        check("t1_next_accept", rc + 1 - e0, T_NEXT);
        check("t1_first_rise", first_rise - e0, T_FIRST);
        check("t1_last_rise", last_rise - e0, T_LAST);
        check("t1_rises", rises, W);
        check("t1_ssel_rise", ssel_rise - e0, T_END);
        check("t1_done_cyc", done_cyc - e0, T_END);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_busy_idle", busy, 0);
        check_rx("t1", w);

        // Back-to-back frames with tx_valid held high
        w  = 64'h8000_0000_0000_0001;
        w2 = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_ready(rc);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        e0 = cyc;
        tx_data = w2;
        wait_ready(rc);
        @(negedge clk);
        e1 = cyc;
        tx_valid = 1'b0;
        check("t2_second_start", e1 - e0, T_NEXT);
        check("t2_ssel_low", ssel, 0);
        wait_ready(rc);
        check("t2_gap", last_gap, GAPC);
        check("t2_done_cnt", done_cnt, 3);
        check_rx("t2a", w);
        check_rx("t2b", w2);

        // Requests and data changes while busy are ignored
        w  = 64'h5A5A_0F0F_C3C3_1234;
        fs = frames_started;
        send(w, e0);
        while (cyc < e0 + 100) @(negedge clk);
        tx_data = 64'hAAAA_AAAA_AAAA_AAAA;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        while (cyc < e0 + 300) @(negedge clk);
        tx_data = 64'h1111_2222_3333_4444;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_ready(rc);
        repeat (30) @(negedge clk);
        check("t3_frames", frames_started - fs, 1);
        check("t3_idle_ssel", ssel, 1);
        check_rx("t3", w);

        // Reset in the middle of a frame
        w = {$urandom(), $urandom()};
        pb = partial;
        send(w, e0);
        while (cyc < e0 + 200) @(negedge clk);
        dc = done_cnt;
        #1 rst = 1'b1;
        #1;
        check("t4_ssel", ssel, 1);
        check("t4_sck", sck, 0);
        check("t4_mosi", mosi, 0);
        check("t4_busy", busy, 0);
        check("t4_ready", tx_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_partial", partial - pb, 1);
        check("t4_no_done", done_cnt, dc);
        check("t4_no_word", rx_q.size(), 0);
        w = 64'hDEAD_BEEF_0000_0001;
        send(w, e0);
        wait_ready(rc);
        check_rx("t4", w);

        // Random words, random idle gaps and stray requests while busy
        pb = partial;
        ds = done_cnt;
        for (int i = 0; i < 40; i++) begin
            w = {$urandom(), $urandom()};
            exp_q.push_back(w);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(w, e0);
            if ($urandom_range(0, 1) == 1) begin
                while (cyc < e0 + int'($urandom_range(10, 480))) @(negedge clk);
                tx_data = {$urandom(), $urandom()};
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
            wait_ready(rc);
            check("t5_rises", rises, W);
            check_rx("t5", exp_q.pop_front());
        end
        check("t5_done_cnt", done_cnt - ds, 40);
        check("t5_partial", partial - pb, 0);
        check("proto_errors", proto_err, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
